juego_led_control: RTL
======================

// Module: juego_led_control
// PURPOSE
//  Game sequencer for the LED reaction game on the 1 kHz domain. Lights a pseudo-random target LED,
//  opens a response window, and scores the one-cycle impulso from the button pulse-to-impulse stage.
//  Drives NumLEDs (difficulty level) back to that stage. Tracks score and lives; ends at zero lives.
// PARAMETERS
//  SHOW_MS    500  base response window in clock1k cycles (level 0)
//  GAP_MS     200  dark gap between rounds, cycles
//  MAX_LIVES  3    lives loaded at game start (1..3)
//  SCORE_W    8    score width; score saturates at 2**SCORE_W-1
//  HITS_LVL   4    consecutive hits needed to raise level
// PORTS
//  clock1k   in   1        1 kHz system clock; everything is on its rising edge
//  reset     in   1        synchronous, active-high
//  start     in   1        level/pulse; sampled only in IDLE and OVER
//  impulso   in   1        one-cycle button impulse, already synchronised
//  leds      out  4        one-hot target in SHOW, 0 in GAP/IDLE, 4'hF in OVER
//  NumLEDs   out  2        current level 0..3, also sets window length
//  score     out  SCORE_W  hits this game
//  lives     out  2        remaining lives
//  game_over out  1        high while in OVER
//  busy      out  1        high in ARM/SHOW/HIT/MISS/GAP
//  hiscore   out  SCORE_W  best score (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, leds=0, NumLEDs=0, score=0, lives=0, game_over=0, busy=0, hiscore=0, lfsr=8'hA5.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle incl. IDLE; never reaches 0.
//  Window length W = SHOW_MS >> NumLEDs (min 1); a 16-bit down-counter tmr covers it.
//  IDLE --start--> ARM, loading score=0, lives=MAX_LIVES, NumLEDs=0, hit_run=0.
//  ARM (1 cycle): tgt=lfsr[1:0]; if tgt==previous tgt use tgt+1 (mod 4); tmr=W-1 -> SHOW.
//  SHOW: leds=1<<tgt. impulso -> HIT. tmr==0 && !impulso -> MISS. Else tmr--.
//   impulso on the same cycle as tmr==0 counts as HIT (hit wins).
//  HIT (1 cycle): score+1 saturating; hit_run+1; if hit_run+1==HITS_LVL: NumLEDs+1 capped at 3,
//   hit_run=0. -> GAP with tmr=GAP_MS-1.
//  MISS (1 cycle): hit_run=0; lives-1; if result 0 -> OVER, else -> GAP with tmr=GAP_MS-1.
//  GAP: leds=0; impulso ignored; tmr==0 -> ARM else tmr--.
//  OVER: leds=4'hF, game_over=1, score/lives/NumLEDs held; start -> ARM with IDLE's start loads.
//  start outside IDLE/OVER ignored; impulso outside SHOW ignored (no penalty).
//  Outputs registered: state change visible on the cycle after the triggering edge.
//  reset asserted mid-game overrides everything on that edge and returns to reset values.
// CONFIGURATION
//  JUEGO_LED_HISCORE_EN defined: on OVER entry, if score>hiscore then hiscore<=score; kept across
//   games, cleared only by reset.
//  Not defined: no hiscore register; hiscore port tied to 0.
// STRUCTURE
//  Shared package juego_led_pkg: state encodings (IDLE,ARM,SHOW,HIT,MISS,GAP,OVER), LFSR seed
//   8'hA5 and tap mask, LVL_MAX=3, LED count 4.
//  One sub-module: juego_led_lfsr (8-bit, sync reset to seed, enable tied high here).
//  Top holds FSM, tmr, score/lives/level counters.
// TESTING (SHOW_MS=8, GAP_MS=2, MAX_LIVES=3, HITS_LVL=4)
//  Reset then idle 20 cycles: all outputs at reset values; impulso pulses change nothing.
//  start, then impulso 3 cycles into SHOW: score 0->1, leds one-hot then 0 for 2 cycles, next ARM.
//  start, no impulso: MISS after 8 SHOW cycles; after 3 rounds lives=0, game_over=1, leds=4'hF.
//  4 consecutive hits: NumLEDs 0->1, next window 4 cycles; 16 hits: NumLEDs stays 3 (W=1).
//  impulso exactly on last SHOW cycle: HIT; reset asserted during SHOW: reset values next cycle.
//  With JUEGO_LED_HISCORE_EN: game1 score 5, game2 score 2 -> hiscore 5; without: hiscore 0.

Source files
------------

// File: rtl/juego_led_pkg.sv
// Shared definitions for the LED reaction game: state encodings,
// LFSR seed/taps, level ceiling and window-length helper.
package juego_led_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_SHOW = 3'd2,
        S_HIT  = 3'd3,
        S_MISS = 3'd4,
        S_GAP  = 3'd5,
        S_OVER = 3'd6
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 (maximal length)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
    localparam logic [1:0] LVL_MAX   = 2'd3;
    localparam int         NUM_LEDS  = 4;

    function automatic logic [15:0] win_len(
        input logic [15:0] base,
        input logic [1:0]  lvl
    );
        logic [15:0] w;
        w = base >> lvl;
        return (w == 16'd0) ? 16'd1 : w;
    endfunction

endpackage

// File: rtl/juego_led_lfsr.sv
// 8-bit Fibonacci LFSR, synchronous reset to the shared seed.
// Only the two low bits are exported as the random LED pick.
module juego_led_lfsr
    import juego_led_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] rnd
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q[1:0];

endmodule

// File: rtl/juego_led_control.sv
// LED reaction game sequencer: target pick, response window, scoring, lives.
// Define JUEGO_LED_HISCORE_EN to keep a best-score register across games.
module juego_led_control
    import juego_led_pkg::*;
#(
    parameter int SHOW_MS   = 500,
    parameter int GAP_MS    = 200,
    parameter int MAX_LIVES = 3,
    parameter int SCORE_W   = 8,
    parameter int HITS_LVL  = 4
) (
    input  logic                clock1k,
    input  logic                reset,
    input  logic                start,
    input  logic                impulso,
    output logic [NUM_LEDS-1:0] leds,
    output logic [1:0]          NumLEDs,
    output logic [SCORE_W-1:0]  score,
    output logic [1:0]          lives,
    output logic                game_over,
    output logic                busy,
    output logic [SCORE_W-1:0]  hiscore
);

    localparam logic [15:0]        SHOW_BASE = 16'(SHOW_MS);
    localparam logic [15:0]        GAP_LOAD  = 16'(GAP_MS - 1);
    localparam logic [1:0]         LIVES_LD  = 2'(MAX_LIVES);
    localparam logic [7:0]         RUN_LAST  = 8'(HITS_LVL - 1);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    state_e              state_q, state_d;
    logic [15:0]         tmr_q, tmr_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [1:0]          lvl_q, lvl_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [1:0]          lives_q, lives_d;
    logic [7:0]          run_q, run_d;
    logic [1:0]          rnd;

    juego_led_lfsr u_lfsr (
        .clk (clock1k),
        .rst (reset),
        .en  (1'b1),
        .rnd (rnd)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        tgt_d   = tgt_q;
        lvl_d   = lvl_q;
        score_d = score_q;
        lives_d = lives_q;
        run_d   = run_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_ARM;
                    score_d = '0;
                    lives_d = LIVES_LD;
                    lvl_d   = 2'd0;
                    run_d   = 8'd0;
                end
            end
            S_ARM: begin
                // never light the same LED twice in a row
                tgt_d   = (rnd == tgt_q) ? rnd + 2'd1 : rnd;
                tmr_d   = win_len(SHOW_BASE, lvl_q) - 16'd1;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (impulso) begin
                    state_d = S_HIT;
                end else if (tmr_q == 16'd0) begin
                    state_d = S_MISS;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_HIT: begin
                if (score_q != '1) begin
                    score_d = score_q + SCORE_ONE;
                end
                if (run_q == RUN_LAST) begin
                    run_d = 8'd0;
                    if (lvl_q != LVL_MAX) begin
                        lvl_d = lvl_q + 2'd1;
                    end
                end else begin
                    run_d = run_q + 8'd1;
                end
                tmr_d   = GAP_LOAD;
                state_d = S_GAP;
            end
            S_MISS: begin
                run_d   = 8'd0;
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_d = S_OVER;
                end else begin
                    tmr_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_q == 16'd0) begin
                    state_d = S_ARM;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock1k) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            tgt_q   <= '0;
            lvl_q   <= '0;
            score_q <= '0;
            lives_q <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            tgt_q   <= tgt_d;
            lvl_q   <= lvl_d;
            score_q <= score_d;
            lives_q <= lives_d;
            run_q   <= run_d;
        end
    end

`ifdef JUEGO_LED_HISCORE_EN
    logic [SCORE_W-1:0] hi_q, hi_d;

    // latch the final score on the MISS that ends the game
    always_comb begin
        hi_d = hi_q;
        if (state_q == S_MISS && lives_q == 2'd1 && score_q > hi_q) begin
            hi_d = score_q;
        end
    end

    always_ff @(posedge clock1k) begin
        if (reset) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign hiscore = hi_q;
`else
    assign hiscore = '0;
`endif

    always_comb begin
        leds = '0;
        unique case (state_q)
            S_SHOW:  leds = NUM_LEDS'(1) << tgt_q;
            S_OVER:  leds = '1;
            default: leds = '0;
        endcase
    end

    assign busy      = (state_q == S_ARM)  || (state_q == S_SHOW) ||
                       (state_q == S_HIT)  || (state_q == S_MISS) ||
                       (state_q == S_GAP);
    assign game_over = (state_q == S_OVER);
    assign NumLEDs   = lvl_q;
    assign score     = score_q;
    assign lives     = lives_q;

endmodule
